// File: rtl/ram_arb_pkg.sv
// Shared types and default widths for the ram4k arbiter.
package ram_arb_pkg;

  localparam int DEF_DATA_W = 16;
  localparam int DEF_ADDR_W = 12;

  typedef enum logic {
    IDLE  = 1'b0,
    CLEAR = 1'b1
  } arb_state_t;

  // Requester id: 0 = CPU data port, 1 = DMA / screen refresh.
  typedef logic req_id_t;

  // Read-return tag carried alongside the RAM read latency.
  typedef struct packed {
    logic    vld;
    req_id_t id;
  } rd_tag_t;

endpackage

// File: rtl/ram_arbiter_if.sv
// Requester, clear-control and ram4k-side signals of the arbiter.
interface ram_arbiter_if #(
  parameter int DATA_W = 16,
  parameter int ADDR_W = 12
);
  logic              req0, req1;
  logic              we0, we1;
  logic [ADDR_W-1:0] addr0, addr1;
  logic [DATA_W-1:0] wdata0, wdata1;
  logic              gnt0, gnt1;
  logic              rvalid0, rvalid1;
  logic [DATA_W-1:0] rdata0, rdata1;
  logic              clear_start;
  logic              busy;
  logic              clear_done;
  logic              ram_load;
  logic [ADDR_W-1:0] ram_address;
  logic [DATA_W-1:0] ram_data_in;
  logic [DATA_W-1:0] ram_data_out;

  // Arbiter side.
  modport slave (
    input  req0, req1, we0, we1, addr0, addr1, wdata0, wdata1,
    input  clear_start, ram_data_out,
    output gnt0, gnt1, rvalid0, rvalid1, rdata0, rdata1,
    output busy, clear_done, ram_load, ram_address, ram_data_in
  );

  // Requesters plus RAM (environment) side.
  modport master (
    output req0, req1, we0, we1, addr0, addr1, wdata0, wdata1,
    output clear_start, ram_data_out,
    input  gnt0, gnt1, rvalid0, rvalid1, rdata0, rdata1,
    input  busy, clear_done, ram_load, ram_address, ram_data_in
  );
endinterface

// File: rtl/ram_arbiter_rd_tag_pipe.sv
// RD_LAT-deep shift register of read tags; its tail routes the rvalid
// pulse to the requester that issued the read RD_LAT cycles earlier.
module rd_tag_pipe
  import ram_arb_pkg::*;
#(
  parameter int RD_LAT = 1
) (
  input  logic    clk,
  input  logic    rst_n,
  input  rd_tag_t tag_in,
  output logic    rvalid0,
  output logic    rvalid1
);

  rd_tag_t [RD_LAT-1:0] tag_pipe_q;
  rd_tag_t [RD_LAT-1:0] tag_pipe_d;

  // Shift one stage per cycle; every cycle pushes a tag (invalid when idle).
  always_comb begin
    tag_pipe_d = tag_pipe_q;
    tag_pipe_d[0] = tag_in;
    for (int s = 1; s < RD_LAT; s++) begin
      tag_pipe_d[s] = tag_pipe_q[s-1];
    end
  end

  // Tag register; only reset empties it.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) tag_pipe_q <= '0;
    else        tag_pipe_q <= tag_pipe_d;
  end

  assign rvalid0 = tag_pipe_q[RD_LAT-1].vld && (tag_pipe_q[RD_LAT-1].id == 1'b0);
  assign rvalid1 = tag_pipe_q[RD_LAT-1].vld && (tag_pipe_q[RD_LAT-1].id == 1'b1);

endmodule

// File: rtl/ram_arbiter.sv
// Round-robin two-requester arbiter in front of the single-port ram4k,
// with a built-in sequencer that sweeps the whole memory to zero.
module ram_arbiter
  import ram_arb_pkg::*;
#(
  parameter int DATA_W = DEF_DATA_W,
  parameter int ADDR_W = DEF_ADDR_W,
  parameter int RD_LAT = 1
) (
  input  logic          clk,
  input  logic          rst_n,
  ram_arbiter_if.slave  bus
);

  localparam logic [ADDR_W-1:0] LAST_ADDR = '1;

  arb_state_t        state_q, state_d;
  req_id_t           prio_q, prio_d;
  logic [ADDR_W-1:0] clr_cnt_q, clr_cnt_d;

  logic              gnt0, gnt1;
  logic              ram_load;
  logic [ADDR_W-1:0] ram_address;
  logic [DATA_W-1:0] ram_data_in;
  logic              clear_done;
  rd_tag_t           tag_in;
  logic              rvalid0, rvalid1;

  // Arbitration, clear sweep and RAM command; outputs forced to 0 while
  // rst_n is low so the RAM sees no command during reset.
  always_comb begin
    state_d     = state_q;
    prio_d      = prio_q;
    clr_cnt_d   = clr_cnt_q;
    gnt0        = 1'b0;
    gnt1        = 1'b0;
    ram_load    = 1'b0;
    ram_address = '0;
    ram_data_in = '0;
    clear_done  = 1'b0;
    tag_in      = '0;

    case (state_q)
      IDLE: begin
        if (bus.clear_start) begin
          // Clear wins over any pending request this cycle.
          state_d   = CLEAR;
          clr_cnt_d = '0;
        end else begin
          if (bus.req0 && (!bus.req1 || prio_q == 1'b0)) gnt0 = 1'b1;
          else if (bus.req1)                             gnt1 = 1'b1;

          if (gnt0) begin
            ram_load    = bus.we0;
            ram_address = bus.addr0;
            ram_data_in = bus.wdata0;
            tag_in      = '{vld: !bus.we0, id: 1'b0};
            prio_d      = 1'b1;
          end else if (gnt1) begin
            ram_load    = bus.we1;
            ram_address = bus.addr1;
            ram_data_in = bus.wdata1;
            tag_in      = '{vld: !bus.we1, id: 1'b1};
            prio_d      = 1'b0;
          end
        end
      end
      CLEAR: begin
        // clear_start is ignored here; the sweep is never restarted.
        ram_load    = 1'b1;
        ram_address = clr_cnt_q;
        clr_cnt_d   = clr_cnt_q + 1'b1;
        if (clr_cnt_q == LAST_ADDR) begin
          clear_done = 1'b1;
          state_d    = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase

    if (!rst_n) begin
      gnt0        = 1'b0;
      gnt1        = 1'b0;
      ram_load    = 1'b0;
      ram_address = '0;
      ram_data_in = '0;
      clear_done  = 1'b0;
    end
  end

  // State, priority and clear counter registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      prio_q    <= 1'b0;
      clr_cnt_q <= '0;
    end else begin
      state_q   <= state_d;
      prio_q    <= prio_d;
      clr_cnt_q <= clr_cnt_d;
    end
  end

  rd_tag_pipe #(.RD_LAT(RD_LAT)) u_rd_tag_pipe (
    .clk     (clk),
    .rst_n   (rst_n),
    .tag_in  (tag_in),
    .rvalid0 (rvalid0),
    .rvalid1 (rvalid1)
  );

  assign bus.gnt0        = gnt0;
  assign bus.gnt1        = gnt1;
  assign bus.ram_load    = ram_load;
  assign bus.ram_address = ram_address;
  assign bus.ram_data_in = ram_data_in;
  assign bus.clear_done  = clear_done;
  assign bus.busy        = (state_q == CLEAR);
  assign bus.rvalid0     = rvalid0;
  assign bus.rvalid1     = rvalid1;
  assign bus.rdata0      = rvalid0 ? bus.ram_data_out : '0;
  assign bus.rdata1      = rvalid1 ? bus.ram_data_out : '0;

endmodule

// File: tb/tb_ram_arbiter.sv
// Directed bench for ram_arbiter with a behavioural ram4k (registered read).
module tb_ram_arbiter;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   checks = 0;
  int   errors = 0;

  always #5 clk = ~clk;

  ram_arbiter_if #(.DATA_W(16), .ADDR_W(12)) bus ();

  ram_arbiter dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  // ram4k model plus a backdoor preload port owned by the bench.
  logic [15:0] mem [4096];
  logic        bd_we = 1'b0;
  logic [11:0] bd_addr = '0;
  logic [15:0] bd_data = '0;

  always @(posedge clk) begin
    if (bd_we)             mem[bd_addr] <= bd_data;
    else if (bus.ram_load) mem[bus.ram_address] <= bus.ram_data_in;
    bus.ram_data_out <= mem[bus.ram_address];
  end

  task automatic step();
    @(negedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    bus.req0 = 0; bus.we0 = 0; bus.addr0 = '0; bus.wdata0 = '0;
    bus.req1 = 0; bus.we1 = 0; bus.addr1 = '0; bus.wdata1 = '0;
    bus.clear_start = 0;
  endtask

  task automatic preload(input logic [11:0] a, input logic [15:0] d);
    step(); bd_we = 1; bd_addr = a; bd_data = d;
    step(); bd_we = 0;
  endtask

  // Runs a sweep already started; counts busy cycles and clear_done pulses.
  task automatic sweep_count(input int pulse_at, output int n, output int dc,
                             output int bad_gnt, output int bad_ram);
    n = 0; dc = 0; bad_gnt = 0; bad_ram = 0;
    for (int c = 0; c < 5000; c++) begin
      step();
      bus.clear_start = (n == pulse_at);
      #1;
      if (!bus.busy) break;
      n++;
      if (bus.clear_done) dc += (n == 4096) ? 1 : 100;
      if (bus.gnt0 || bus.gnt1) bad_gnt++;
      if (bus.ram_load !== 1'b1 || bus.ram_address !== 12'(n - 1) || bus.ram_data_in !== 16'h0)
        bad_ram++;
    end
    bus.clear_start = 0;
  endtask

  task automatic test_reset();
    rst_n = 0;
    idle_inputs();
    bus.req0 = 1; bus.we0 = 1; bus.addr0 = 12'h005; bus.wdata0 = 16'h1111;
    #2;
    checks++; if (bus.gnt0 !== 1'b0) begin errors++; $display("FAIL rst_gnt0 got %0b exp 0", bus.gnt0); end
    checks++; if (bus.ram_load !== 1'b0 || bus.ram_address !== 12'h0 || bus.ram_data_in !== 16'h0) begin
      errors++; $display("FAIL rst_ram got %0b/%h/%h exp 0/000/0000", bus.ram_load, bus.ram_address, bus.ram_data_in); end
    checks++; if ({bus.busy, bus.clear_done, bus.rvalid0, bus.rvalid1} !== 4'b0) begin
      errors++; $display("FAIL rst_flags got %b exp 0000", {bus.busy, bus.clear_done, bus.rvalid0, bus.rvalid1}); end
    checks++; if (bus.rdata0 !== 16'h0 || bus.rdata1 !== 16'h0) begin
      errors++; $display("FAIL rst_rdata got %h/%h exp 0/0", bus.rdata0, bus.rdata1); end
    idle_inputs();
    step(); step();
    rst_n = 1;
  endtask

  task automatic test_write_read();
    step();
    bus.req0 = 1; bus.we0 = 1; bus.addr0 = 12'h005; bus.wdata0 = 16'h5678; #1;
    checks++; if (bus.gnt0 !== 1'b1 || bus.gnt1 !== 1'b0) begin errors++; $display("FAIL wr_gnt got %b%b exp 10", bus.gnt0, bus.gnt1); end
    checks++; if (bus.ram_load !== 1'b1 || bus.ram_address !== 12'h005 || bus.ram_data_in !== 16'h5678) begin
      errors++; $display("FAIL wr_ram got %0b/%h/%h exp 1/005/5678", bus.ram_load, bus.ram_address, bus.ram_data_in); end
    step();
    bus.we0 = 0; bus.wdata0 = 16'h0; #1;
    checks++; if (bus.gnt0 !== 1'b1 || bus.ram_load !== 1'b0 || bus.ram_address !== 12'h005) begin
      errors++; $display("FAIL rd_issue got gnt0=%0b load=%0b addr=%h exp 1/0/005", bus.gnt0, bus.ram_load, bus.ram_address); end
    step();
    idle_inputs(); #1;
    checks++; if (bus.rvalid0 !== 1'b1 || bus.rdata0 !== 16'h5678 || bus.rvalid1 !== 1'b0) begin
      errors++; $display("FAIL rd_return got v0=%0b d0=%h v1=%0b exp 1/5678/0", bus.rvalid0, bus.rdata0, bus.rvalid1); end
    step();
    checks++; if (bus.rvalid0 !== 1'b0 || bus.rdata0 !== 16'h0) begin
      errors++; $display("FAIL rd_pulse got v0=%0b d0=%h exp 0/0000", bus.rvalid0, bus.rdata0); end
  endtask

  task automatic test_contention();
    rst_n = 0; step(); rst_n = 1;
    preload(12'h000, 16'h1234);
    preload(12'h12C, 16'habcd);
    for (int i = 0; i < 4; i++) begin
      step();
      bus.req0 = 1; bus.we0 = 0; bus.addr0 = 12'h000;
      bus.req1 = 1; bus.we1 = 0; bus.addr1 = 12'h12C; #1;
      checks++; if (bus.gnt0 !== ((i % 2) == 0) || bus.gnt1 !== ((i % 2) == 1)) begin
        errors++; $display("FAIL rr_gnt%0d got %b%b exp %b%b", i, bus.gnt0, bus.gnt1, (i % 2) == 0, (i % 2) == 1); end
      if (i > 0) begin
        checks++;
        if ((i % 2) == 1) begin
          if (bus.rvalid0 !== 1'b1 || bus.rdata0 !== 16'h1234 || bus.rvalid1 !== 1'b0) begin
            errors++; $display("FAIL rr_ret%0d got v0=%0b d0=%h v1=%0b exp 1/1234/0", i, bus.rvalid0, bus.rdata0, bus.rvalid1); end
        end else begin
          if (bus.rvalid1 !== 1'b1 || bus.rdata1 !== 16'habcd || bus.rvalid0 !== 1'b0) begin
            errors++; $display("FAIL rr_ret%0d got v1=%0b d1=%h v0=%0b exp 1/abcd/0", i, bus.rvalid1, bus.rdata1, bus.rvalid0); end
        end
      end
    end
    step();
    idle_inputs(); #1;
    checks++; if (bus.rvalid1 !== 1'b1 || bus.rdata1 !== 16'habcd || bus.rvalid0 !== 1'b0) begin
      errors++; $display("FAIL rr_last got v1=%0b d1=%h v0=%0b exp 1/abcd/0", bus.rvalid1, bus.rdata1, bus.rvalid0); end
  endtask

  task automatic test_we_zero();
    step();
    bus.req1 = 1; bus.we1 = 1; bus.addr1 = 12'h03E; bus.wdata1 = 16'hdcba; #1;
    checks++; if (bus.gnt1 !== 1'b1 || bus.ram_load !== 1'b1) begin
      errors++; $display("FAIL we_wr got gnt1=%0b load=%0b exp 1/1", bus.gnt1, bus.ram_load); end
    step();
    bus.we1 = 0; bus.wdata1 = 16'hbbbb; #1;
    checks++; if (bus.gnt1 !== 1'b1 || bus.ram_load !== 1'b0) begin
      errors++; $display("FAIL we_rd_load got gnt1=%0b load=%0b exp 1/0", bus.gnt1, bus.ram_load); end
    step();
    #1;
    checks++; if (bus.rvalid1 !== 1'b1 || bus.rdata1 !== 16'hdcba) begin
      errors++; $display("FAIL we_rd1 got v1=%0b d1=%h exp 1/dcba", bus.rvalid1, bus.rdata1); end
    step();
    idle_inputs(); #1;
    checks++; if (bus.rvalid1 !== 1'b1 || bus.rdata1 !== 16'hdcba) begin
      errors++; $display("FAIL we_rd2 got v1=%0b d1=%h exp 1/dcba", bus.rvalid1, bus.rdata1); end
  endtask

  task automatic test_clear();
    int n, dc, bg, br;
    preload(12'hFFF, 16'hdef0);
    step();
    bus.req0 = 1; bus.we0 = 0; bus.addr0 = 12'hFFF; #1;
    checks++; if (bus.gnt0 !== 1'b1) begin errors++; $display("FAIL clr_pre_gnt got %0b exp 1", bus.gnt0); end
    step();
    bus.req0 = 0; bus.clear_start = 1;
    bus.req1 = 1; bus.we1 = 0; bus.addr1 = 12'h070; #1;
    checks++; if (bus.gnt0 !== 1'b0 || bus.gnt1 !== 1'b0 || bus.busy !== 1'b0) begin
      errors++; $display("FAIL clr_start_cyc got gnt=%b%b busy=%0b exp 00/0", bus.gnt0, bus.gnt1, bus.busy); end
    checks++; if (bus.rvalid0 !== 1'b1 || bus.rdata0 !== 16'hdef0) begin
      errors++; $display("FAIL clr_inflight got v0=%0b d0=%h exp 1/def0", bus.rvalid0, bus.rdata0); end
    sweep_count(100, n, dc, bg, br);
    checks++; if (n !== 4096) begin errors++; $display("FAIL clr_busy_len got %0d exp 4096", n); end
    checks++; if (dc !== 1) begin errors++; $display("FAIL clr_done_pulse got code %0d exp 1", dc); end
    checks++; if (bg !== 0) begin errors++; $display("FAIL clr_no_gnt got %0d grants exp 0", bg); end
    checks++; if (br !== 0) begin errors++; $display("FAIL clr_ram_cmd got %0d bad cycles exp 0", br); end
    checks++; if (bus.gnt1 !== 1'b1 || bus.clear_done !== 1'b0) begin
      errors++; $display("FAIL clr_pending_gnt got gnt1=%0b done=%0b exp 1/0", bus.gnt1, bus.clear_done); end
    step();
    bus.req1 = 0; bus.req0 = 1; bus.we0 = 0; bus.addr0 = 12'h000; #1;
    checks++; if (bus.rvalid1 !== 1'b1 || bus.rdata1 !== 16'h0000) begin
      errors++; $display("FAIL clr_rd070 got v1=%0b d1=%h exp 1/0000", bus.rvalid1, bus.rdata1); end
    step();
    bus.addr0 = 12'hFFF; #1;
    checks++; if (bus.rvalid0 !== 1'b1 || bus.rdata0 !== 16'h0000) begin
      errors++; $display("FAIL clr_rd000 got v0=%0b d0=%h exp 1/0000", bus.rvalid0, bus.rdata0); end
    step();
    idle_inputs(); #1;
    checks++; if (bus.rvalid0 !== 1'b1 || bus.rdata0 !== 16'h0000) begin
      errors++; $display("FAIL clr_rdFFF got v0=%0b d0=%h exp 1/0000", bus.rvalid0, bus.rdata0); end
  endtask

  task automatic test_reset_mid_clear();
    int n, dc, bg, br;
    step(); bus.clear_start = 1;
    step(); bus.clear_start = 0;
    n = 0;
    for (int c = 0; c < 200 && n < 50; c++) begin
      step();
      if (bus.busy) n++;
    end
    rst_n = 0; #1;
    checks++; if (bus.busy !== 1'b0 || bus.ram_load !== 1'b0 || bus.ram_address !== 12'h0 || bus.clear_done !== 1'b0) begin
      errors++; $display("FAIL mid_rst got busy=%0b load=%0b addr=%h done=%0b exp 0/0/000/0",
                         bus.busy, bus.ram_load, bus.ram_address, bus.clear_done); end
    step(); step();
    rst_n = 1;
    step();
    checks++; if (bus.busy !== 1'b0) begin errors++; $display("FAIL mid_rst_idle got busy=%0b exp 0", bus.busy); end
    bus.clear_start = 1;
    sweep_count(-1, n, dc, bg, br);
    checks++; if (n !== 4096 || dc !== 1) begin
      errors++; $display("FAIL resweep got len=%0d done=%0d exp 4096/1", n, dc); end
  endtask

  initial begin
    idle_inputs();
    test_reset();
    test_write_read();
    test_contention();
    test_we_zero();
    test_clear();
    test_reset_mid_clear();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/ram_arbiter.md
Name: ram_arbiter

Overview:
Shares the single-port ram4k data memory between two requesters: requester 0 is the CPU data port and requester 1 is a DMA/screen-refresh agent. Each requester uses a req/gnt handshake. Arbitration is round-robin, with one RAM access issued per cycle. A built-in clear sequencer sweeps the whole memory to zero on command, giving a software-visible memory wipe without CPU loops.

Parameters:
DATA_W, 16, RAM word width.
ADDR_W, 12, RAM address width; DEPTH = 2**ADDR_W = 4096 words.
RD_LAT, 1, cycles from RAM address/read issue to valid ram_data_out (ram4k registered read = 1).

Ports:
clk  in  1  clock; all state updates on posedge.
rst_n  in  1  asynchronous active-low reset.
req0, req1  in  1  requester access request; held with command until gnt.
we0, we1  in  1  1 = write, 0 = read.
addr0, addr1  in  ADDR_W  access address.
wdata0, wdata1  in  DATA_W  write data.
gnt0, gnt1  out  1  command accepted this cycle; requester may change its command next cycle.
rvalid0, rvalid1  out  1  read data valid pulse.
rdata0, rdata1  out  DATA_W  read data; 0 when the matching rvalid is low.
clear_start  in  1  single-cycle pulse; begin full-memory clear.
busy  out  1  clear sweep in progress.
clear_done  out  1  one-cycle pulse on the cycle the last clear write issues.
ram_load  out  1  to ram4k load.
ram_address  out  ADDR_W  to ram4k address.
ram_data_in  out  DATA_W  to ram4k data_in.
ram_data_out  in  DATA_W  from ram4k data_out.

Behaviour:
- Reset (async, rst_n=0): state=IDLE, prio=0, clear counter=0, tag pipe empty. All outputs 0: gnt*, rvalid*, rdata*, busy, clear_done, ram_load, ram_address, ram_data_in.
- FSM has two states, IDLE and CLEAR.
- IDLE, arbitration:
  - gnt is combinational from req/prio in the same cycle the RAM command is driven.
  - Only one req high: grant it.
  - Both req high: grant requester prio.
  - After any grant, prio <= id of the non-granted requester (the other id).
  - No req: ram_load=0, ram_address=0, ram_data_in=0.
- Granted command drives RAM combinationally: ram_load=we, ram_address=addr, ram_data_in=wdata. Write completes at the posedge ending the grant cycle.
- Read return:
  - A granted read pushes tag {valid, id} into the RD_LAT-deep shift pipe.
  - rvalid_id pulses exactly RD_LAT cycles after the gnt cycle, with rdata_id = ram_data_out.
  - Back-to-back reads return in issue order, one per cycle.
  - Writes push an invalid tag.
- clear_start in IDLE:
  - Next cycle enters CLEAR, counter=0, busy=1.
  - If clear_start and req coincide, clear wins and no gnt is issued that cycle.
- CLEAR state:
  - Each cycle: ram_load=1, ram_address=counter, ram_data_in=0, then counter+1.
  - No gnt while in CLEAR; requests stay pending.
  - When counter=DEPTH-1: clear_done=1 that cycle, then next state IDLE, busy=0.
  - A sweep is exactly DEPTH cycles of busy. The counter width is ADDR_W; completion is detected on the terminal count, not on wrap.
- clear_start while in CLEAR is ignored; there is no restart.
- Reads in flight when CLEAR starts still return their rvalid normally, with data sampled before the overwrite. The tag pipe is never flushed except by reset.
- Reset mid-CLEAR aborts immediately. Memory is left partially cleared, which is acceptable; there is no resume.
- First arbitration after CLEAR uses the prio value held from before CLEAR.

Decomposition:
- Shared package ram_arb_pkg holds:
  - DATA_W/ADDR_W defaults.
  - typedef enum logic {IDLE, CLEAR} arb_state_t.
  - typedef logic req_id_t.
  - typedef struct packed {logic vld; req_id_t id;} rd_tag_t.
- Sub-module rd_tag_pipe: parameterised RD_LAT-deep rd_tag_t shift register with async reset, producing rvalid0/rvalid1 routing.

Test Plan:
- Write then read, single requester: req0 we0=1 addr0=12'h005 wdata0=16'h5678 → gnt0 same cycle. Next, read 12'h005 → rvalid0 1 cycle after gnt with rdata0=16'h5678; rvalid1 stays 0.
- Contention, both req held 4 cycles after reset: grants go 0,1,0,1. Reads to 12'h000/12'h12C, preloaded 16'h1234/16'habcd, return on the correct rvalid lines in order.
- Write with we=0: read 12'h03E after writing 16'hdcba, with wdata=16'hbbbb presented on a read → memory keeps 16'hdcba.
- Clear: preload 12'hFFF=16'hdef0, then pulse clear_start → busy high exactly 4096 cycles, clear_done on the last cycle, no gnt meanwhile. Subsequent reads of 12'h000, 12'h070 and 12'hFFF return 16'h0000.
- Read issued the cycle before clear_start: rvalid still fires with pre-clear data. A clear_start pulse at cycle 100 of the sweep does not extend busy.
- rst_n low at sweep cycle 50 → all outputs 0 asynchronously and state IDLE; a new clear_start runs a full 4096-cycle sweep.
